// File: rtl/qupls_pushpop_expander_pkg.sv
// Shared opcodes, micro-op field positions and FSM state type for the push/pop expander.
// Field positions match where the Ra/Rt decoders extract from.
package QuplsPkg;

    localparam logic [6:0] OP_LOAD  = 7'h03;
    localparam logic [6:0] OP_ADDI  = 7'h13;
    localparam logic [6:0] OP_STORE = 7'h23;

    localparam int OPC_LSB  = 0;
    localparam int RT_LSB   = 7;
    localparam int RA_LSB   = 13;
    localparam int DISP_LSB = 19;
    localparam int REG_W    = 6;
    localparam int DISP_W   = 22;
    localparam int UOP_W    = DISP_LSB + DISP_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        ADJ  = 2'd2
    } pushpop_state_t;

    function automatic logic [UOP_W-1:0] pack_uop(
        input logic [6:0]        op,
        input logic [REG_W-1:0]  rt,
        input logic [REG_W-1:0]  ra,
        input logic [DISP_W-1:0] disp
    );
        logic [UOP_W-1:0] u;
        u = '0;
        u[OPC_LSB  +: 7]      = op;
        u[RT_LSB   +: REG_W]  = rt;
        u[RA_LSB   +: REG_W]  = ra;
        u[DISP_LSB +: DISP_W] = disp;
        return u;
    endfunction

endpackage

// File: rtl/qupls_pushpop_expander_ffs16.sv
// Lowest-set-bit encoder for a 16-bit mask; purely combinational.
module qupls_ffs16 (
    input  logic [15:0] i_vec,
    output logic [3:0]  o_idx,
    output logic        o_any
);

    always_comb begin
        o_idx = '0;
        o_any = |i_vec;
        for (int i = 15; i >= 0; i--) begin
            if (i_vec[i]) o_idx = 4'(i);
        end
    end

endmodule

// File: rtl/qupls_pushpop_expander.sv
// Expands PUSH/POP register-mask macro-ops into one load/store per register plus an SP adjust.
// Optional QUPLS_UOP_STATS_EN adds a free-running handshake counter port uop_count.
module qupls_pushpop_expander
    import QuplsPkg::*;
#(
    parameter int IW         = 41,
    parameter int SP_REG     = 63,
    parameter int WORD_BYTES = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_is_pop,
    input  logic [15:0]   in_mask,
    input  logic [5:0]    in_base,
    input  logic          in_regx,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [IW-1:0] out_instr,
    output logic          out_regx,
    output logic          out_last
`ifdef QUPLS_UOP_STATS_EN
    ,
    output logic [31:0]   uop_count
`endif
);

    pushpop_state_t r_state, w_state_nxt;

    logic        r_started;
    logic        r_pop;
    logic [15:0] r_mask;
    logic [5:0]  r_base;
    logic        r_regx;
    logic [4:0]  r_n;
    logic [3:0]  r_k;

    logic [3:0]  w_idx;
    logic        w_any;
    logic [15:0] w_mask_clr;
    logic        w_hs;
    logic        w_accept;
    logic [5:0]  w_sp;
    logic [21:0] w_bytes;

    qupls_ffs16 u_ffs (
        .i_vec (r_mask),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    assign w_sp       = 6'(SP_REG);
    assign w_bytes    = 22'(WORD_BYTES);
    assign w_mask_clr = r_mask & (r_mask - 16'd1);
    assign w_hs       = out_valid && out_ready && !flush;
    assign w_accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (w_accept && (in_mask != 16'd0)) w_state_nxt = EMIT;
            EMIT: if (w_hs && (w_mask_clr == 16'd0))  w_state_nxt = ADJ;
            ADJ:  if (w_hs)                           w_state_nxt = IDLE;
            default:                                  w_state_nxt = IDLE;
        endcase
        if (flush) w_state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_started <= 1'b0;
            r_pop     <= 1'b0;
            r_mask    <= '0;
            r_base    <= '0;
            r_regx    <= 1'b0;
            r_n       <= '0;
            r_k       <= '0;
        end else begin
            r_started <= 1'b1;
            if (flush) begin
                r_mask <= '0;
            end else if (r_state == IDLE && w_accept) begin
                r_pop  <= in_is_pop;
                r_mask <= in_mask;
                r_base <= in_base;
                r_regx <= in_regx;
                r_n    <= 5'($countones(in_mask));
                r_k    <= '0;
            end else if (r_state == EMIT && w_hs) begin
                r_mask <= w_mask_clr;
                r_k    <= r_k + 4'd1;
            end
        end
    end

    // Outputs are decoded from registered state only, so they cannot move during a stall.
    always_comb begin
        logic [5:0]  rt;
        logic [21:0] disp;
        logic [6:0]  op;
        rt        = w_sp;
        disp      = '0;
        op        = OP_ADDI;
        in_ready  = r_started && (r_state == IDLE) && !flush;
        out_valid = ((r_state == EMIT) && w_any) || (r_state == ADJ);
        out_last  = (r_state == ADJ);
        out_regx  = out_valid ? r_regx : 1'b0;
        out_instr = '0;
        if (r_state == EMIT) begin
            rt = r_base + 6'(w_idx);
            if (r_pop) begin
                op   = OP_LOAD;
                disp = (22'(r_n) - 22'd1 - 22'(r_k)) * w_bytes;
            end else begin
                op   = OP_STORE;
                disp = -((22'(r_k) + 22'd1) * w_bytes);
            end
        end else begin
            disp = r_pop ? (22'(r_n) * w_bytes) : -(22'(r_n) * w_bytes);
        end
        if (out_valid) out_instr[UOP_W-1:0] = pack_uop(op, rt, w_sp, disp);
    end

`ifdef QUPLS_UOP_STATS_EN
    // A handshake coinciding with flush is discarded, so it is not counted either.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            uop_count <= '0;
        end else if (w_hs) begin
            uop_count <= uop_count + 32'd1;
        end
    end
`endif

endmodule

// File: doc/qupls_pushpop_expander.md
Name: qupls_pushpop_expander

Overview:
- Sequential micro-op generator in the decode stage that builds register fields, opposite to field extraction.
- Accepts one PUSH or POP macro-instruction carrying a 16-bit register mask.
- Emits one packed store or load micro-instruction per set mask bit, then one stack-pointer adjust instruction.
- Register fields are encoded at the positions the Ra/Rt decoders extract from.

Parameters:
- IW, 41: micro-instruction width.
- SP_REG, 63: architectural stack-pointer register number, 6 bits.
- WORD_BYTES, 8: bytes per register slot.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous abort of the current expansion.
- in_valid  in  1  macro-op valid.
- in_ready  out  1  block can accept a macro-op.
- in_is_pop  in  1  0 = PUSH, 1 = POP.
- in_mask  in  16  bit i selects register (in_base + i) mod 64.
- in_base  in  6  first register of the mask window.
- in_regx  in  1  register-extension bit, copied to every micro-op.
- out_valid  out  1  micro-op valid.
- out_ready  in  1  downstream accepts the micro-op.
- out_instr  out  IW  packed micro-op.
- out_regx  out  1  extension bit for the Ra/Rt fields.
- out_last  out  1  marks the final micro-op of the macro-op.

Behaviour:
- Reset values: in_ready=0, out_valid=0, out_instr=0, out_regx=0, out_last=0. State is IDLE.
- After reset is released, in_ready rises on the first clock edge.
- Packing of out_instr:
  - [6:0] opcode.
  - [12:7] Rt.
  - [18:13] Ra.
  - [40:19] disp, a 22-bit two's-complement value.
  - Bits above 40 are zero when IW > 41.
- State IDLE:
  - in_ready=1.
  - On in_valid: latch is_pop, mask, base and regx.
  - Compute n = popcount(mask), using 5 bits.
  - Clear slot index k to 0.
  - If mask = 0, stay in IDLE and emit nothing; the macro-op is consumed in one cycle.
  - Otherwise go to EMIT. The first micro-op is presented in the cycle after acceptance.
- State EMIT:
  - r = (base + ffs(mask)) mod 64, where ffs is the lowest set bit.
  - PUSH emits opcode OP_STORE, Rt=r, Ra=SP_REG, disp = -(k+1)*WORD_BYTES.
  - POP emits opcode OP_LOAD, Rt=r, Ra=SP_REG, disp = (n-1-k)*WORD_BYTES.
  - On out_valid && out_ready: clear that mask bit and increment k.
  - When the mask becomes zero, go to ADJ.
- State ADJ:
  - Emits opcode OP_ADDI with Rt=SP_REG, Ra=SP_REG, out_last=1.
  - disp = -n*WORD_BYTES for PUSH, +n*WORD_BYTES for POP.
  - On handshake, go to IDLE.
  - in_ready stays 0 in the handshake cycle and rises on the next cycle.
- Output handshake rules:
  - out_valid, out_instr, out_regx and out_last hold stable while out_valid && !out_ready.
  - out_instr only changes after a completed handshake.
- Back-to-back macro-ops have one idle cycle between the ADJ handshake and the next acceptance.
- flush:
  - Takes priority over every other event in every state.
  - Next cycle: state IDLE, out_valid=0, latched mask cleared, nothing further emitted.
  - A handshake in the same cycle as flush is ignored.
- Reset asserted mid-expansion clears all state asynchronously; no partial micro-op is emitted afterwards.
- Mask wrap: base + i wraps modulo 64. Example: base=60, bit 5 gives register 1.
- Maximum n is 16, so the largest |disp| is 128, well inside 22 bits.

Optional Feature:
- Macro: QUPLS_UOP_STATS_EN.
- Defined: adds output port uop_count (32 bits).
  - Resets to 0.
  - Increments on every out_valid && out_ready, including ADJ.
  - Not cleared by flush; wraps at 2^32.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- QuplsPkg holds:
  - OP_STORE, OP_LOAD and OP_ADDI opcode constants.
  - Field position constants for the Rt, Ra and disp fields.
  - The pushpop_state_t enum (IDLE, EMIT, ADJ).
- One sub-module, qupls_ffs16: combinational lowest-set-bit encoder with a 4-bit index output and an any-set flag.

Test Plan:
- PUSH, mask=16'h0005, base=0, out_ready=1 → STORE Rt=0 disp=-8; STORE Rt=2 disp=-16; ADDI SP disp=-16 with out_last=1. Total 3 beats, then in_ready=1.
- POP, mask=16'h8001, base=60 → LOAD Rt=60 disp=8; LOAD Rt=11 disp=0; ADDI SP disp=+16 with out_last.
- mask=0, PUSH → accepted with in_ready=1 held, out_valid never asserts.
- PUSH mask=16'hFFFF with out_ready toggling 1,0,0,1... → 17 beats; out_instr stable during stalls; last disp=-128.
- flush asserted after the second beat of an 8-register PUSH → out_valid=0 next cycle, in_ready=1, no ADDI emitted.
- rst_n pulsed low mid-EMIT, asynchronously off the clock edge → outputs zero immediately; with QUPLS_UOP_STATS_EN, uop_count=0.
